// File: rtl/spawn_arbiter_queue.sv
// spawn_arbiter_queue
//   Collects spawn requests from PROC_CNT processors and picks one per cycle
//   round-robin. The chosen spawn address goes into a DEPTH-entry FIFO that
//   the dispatcher drains from the head.
//
// Ports
//   clock            in   single clock, all state on posedge
//   reset            in   asynchronous, active-high
//   proc_onspawn     in   [PROC_CNT]         per-proc request, held until acked
//   proc_spawn_addr  in   [ADDR_W*PROC_CNT]  proc i at [i*ADDR_W +: ADDR_W]
//   proc_spawn_ack   out  [PROC_CNT]         one-cycle pulse: request stored
//   deq              in   pop head entry (ignored while empty)
//   deq_addr         out  [ADDR_W]           head entry (show-ahead), 0 while empty
//   empty            out  count == 0
//   full             out  count == DEPTH
//   count            out  [$clog2(DEPTH)+1]  current occupancy
//
// Build option
//   SPAWN_QUEUE_STATS_EN adds peak_count (max occupancy since reset) and
//   spawn_total (16-bit wrapping count of accepted pushes).
module spawn_arbiter_queue #(
    parameter int unsigned PROC_CNT = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [PROC_CNT-1:0]          proc_onspawn,
    input  logic [ADDR_W*PROC_CNT-1:0]   proc_spawn_addr,
    output logic [PROC_CNT-1:0]          proc_spawn_ack,
    input  logic                         deq,
    output logic [ADDR_W-1:0]            deq_addr,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count
`ifdef SPAWN_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]       peak_count,
    output logic [15:0]                  spawn_total
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned IDX_W = (PROC_CNT > 1) ? $clog2(PROC_CNT) : 1;

    logic [ADDR_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic [PROC_CNT-1:0] ack_q, ack_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   head_q, head_d;

    logic [ADDR_W-1:0]   addr_arr_c [PROC_CNT];
    logic [PROC_CNT-1:0] eligible_c;
    logic                win_valid_c;
    logic [IDX_W-1:0]    win_idx_c;
    logic                push_c;
    logic                pop_c;
    logic [ADDR_W-1:0]   push_addr_c;

    // Unpack the flat per-processor address bus
    always_comb begin
        for (int unsigned p = 0; p < PROC_CNT; p++) begin
            addr_arr_c[p] = proc_spawn_addr[p*ADDR_W +: ADDR_W];
        end
    end

    // Round-robin search from rr_ptr; a proc acked last cycle is masked so a
    // request still held during its ack cycle is not stored twice
    always_comb begin
        logic [IDX_W-1:0] idx;
        eligible_c  = proc_onspawn & ~ack_q;
        win_valid_c = 1'b0;
        win_idx_c   = '0;
        idx         = '0;
        for (int unsigned k = 0; k < PROC_CNT; k++) begin
            idx = IDX_W'((32'(rr_ptr_q) + k) % PROC_CNT);
            if (!win_valid_c && eligible_c[idx]) begin
                win_valid_c = 1'b1;
                win_idx_c   = idx;
            end
        end
    end

    // Push/pop decision and next-state for pointers, count, acks and head
    always_comb begin
        pop_c       = deq && !empty_q;
        push_c      = win_valid_c && (!full_q || pop_c);
        push_addr_c = addr_arr_c[win_idx_c];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ack_d    = '0;
        rr_ptr_d = rr_ptr_q;

        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c) begin
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            ack_d[win_idx_c] = 1'b1;
            rr_ptr_d         = (win_idx_c == IDX_W'(PROC_CNT - 1)) ? '0
                                                                  : win_idx_c + IDX_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));

        // The slot being written becomes the head only when it lands at rd_ptr_d
        if (empty_d) begin
            head_d = '0;
        end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_addr_c;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ack_q    <= '0;
            rr_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ack_q    <= ack_d;
            rr_ptr_q <= rr_ptr_d;
            head_q   <= head_d;
        end
    end

    // Storage; contents are masked by the pointers so no reset is needed
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= push_addr_c;
        end
    end

    assign proc_spawn_ack = ack_q;
    assign deq_addr       = head_q;
    assign empty          = empty_q;
    assign full           = full_q;
    assign count          = count_q;

`ifdef SPAWN_QUEUE_STATS_EN
    logic [CNT_W-1:0] peak_q, peak_d;
    logic [15:0]      total_q, total_d;

    // Peak tracks the post-edge occupancy; total wraps naturally
    always_comb begin
        peak_d  = (count_d > peak_q) ? count_d : peak_q;
        total_d = total_q + 16'(push_c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak_q  <= '0;
            total_q <= '0;
        end else begin
            peak_q  <= peak_d;
            total_q <= total_d;
        end
    end

    assign peak_count  = peak_q;
    assign spawn_total = total_q;
`endif

endmodule

// File: tb/tb_spawn_arbiter_queue.sv
// Bench for spawn_arbiter_queue (PROC_CNT=4, ADDR_W=8, DEPTH=16): a vector
// table, directed corner sequences and a randomized run against a queue model.
module tb_spawn_arbiter_queue;

    localparam int unsigned PROC_CNT = 4;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DEPTH    = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  proc_onspawn;
    logic [31:0] proc_spawn_addr;
    logic [3:0]  proc_spawn_ack;
    logic        deq;
    logic [7:0]  deq_addr;
    logic        empty;
    logic        full;
    logic [4:0]  count;
`ifdef SPAWN_QUEUE_STATS_EN
    logic [4:0]  peak_count;
    logic [15:0] spawn_total;
`endif

    logic [7:0]  addr_a [4];

    always_comb proc_spawn_addr = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};

    spawn_arbiter_queue #(.PROC_CNT(PROC_CNT), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .proc_onspawn    (proc_onspawn),
        .proc_spawn_addr (proc_spawn_addr),
        .proc_spawn_ack  (proc_spawn_ack),
        .deq             (deq),
        .deq_addr        (deq_addr),
        .empty           (empty),
        .full            (full),
        .count           (count)
`ifdef SPAWN_QUEUE_STATS_EN
        ,
        .peak_count      (peak_count),
        .spawn_total     (spawn_total)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queue, ack vector and round-robin start index
    logic [7:0] mq [$];
    logic [3:0] m_ack;
    int         m_rr;
    int         m_peak;
    int         m_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ack   = '0;
        m_rr    = 0;
        m_peak  = 0;
        m_total = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs now applied
    task automatic model_step();
        int  win;
        bit  pop;
        bit  acc;
        win = -1;
        pop = deq && (mq.size() > 0);
        for (int k = 0; k < PROC_CNT; k++) begin
            int i;
            i = (m_rr + k) % PROC_CNT;
            if (win < 0 && proc_onspawn[i] && !m_ack[i]) win = i;
        end
        acc = (win >= 0) && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        m_ack = '0;
        if (acc) begin
            mq.push_back(addr_a[win]);
            m_ack[win] = 1'b1;
            m_rr = (win + 1) % PROC_CNT;
            m_total = (m_total + 1) % 65536;
        end
        if (mq.size() > m_peak) m_peak = mq.size();
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(mq.size()));
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, "_full"},  32'(full),  32'(mq.size() == DEPTH));
        chk({tag, "_ack"},   32'(proc_spawn_ack), 32'(m_ack));
        chk({tag, "_head"},  32'(deq_addr), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
`ifdef SPAWN_QUEUE_STATS_EN
        chk({tag, "_peak"},  32'(peak_count), 32'(m_peak));
        chk({tag, "_total"}, 32'(spawn_total), 32'(m_total));
`endif
    endtask

    // Reset pulse between edges; leaves time at posedge+1
    task automatic do_reset();
        @(posedge clock);
        #1;
        proc_onspawn = '0;
        deq          = 1'b0;
        reset        = 1'b1;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_ack",   32'(proc_spawn_ack), 32'd0);
        chk("rst_head",  32'(deq_addr), 32'd0);
        #4;
        reset = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] addrs;
        logic        deq;
        logic [3:0]  exp_ack;
        logic [4:0]  exp_cnt;
        logic        exp_empty;
        logic [7:0]  exp_head;
    } vec_t;

    vec_t vecs [10];

    initial begin
        reset        = 1'b1;
        proc_onspawn = '0;
        deq          = 1'b0;
        for (int p = 0; p < 4; p++) addr_a[p] = '0;
        model_reset();
        #12;

        // ---- vector table: simultaneous requests, pops, empty-pop, push+pop on empty
        vecs[0] = '{4'b1010, 32'h3000_1000, 1'b0, 4'b0010, 5'd1, 1'b0, 8'h10};
        vecs[1] = '{4'b1000, 32'h3000_1000, 1'b0, 4'b1000, 5'd2, 1'b0, 8'h10};
        vecs[2] = '{4'b0000, 32'h3000_1000, 1'b0, 4'b0000, 5'd2, 1'b0, 8'h10};
        vecs[3] = '{4'b0000, 32'h3000_1000, 1'b1, 4'b0000, 5'd1, 1'b0, 8'h30};
        vecs[4] = '{4'b0000, 32'h3000_1000, 1'b1, 4'b0000, 5'd0, 1'b1, 8'h00};
        vecs[5] = '{4'b0000, 32'h3000_1000, 1'b1, 4'b0000, 5'd0, 1'b1, 8'h00};
        vecs[6] = '{4'b0001, 32'h0000_0005, 1'b1, 4'b0001, 5'd1, 1'b0, 8'h05};
        vecs[7] = '{4'b0000, 32'h0000_0005, 1'b1, 4'b0000, 5'd0, 1'b1, 8'h00};
        vecs[8] = '{4'b0100, 32'h00EE_0000, 1'b0, 4'b0100, 5'd1, 1'b0, 8'hEE};
        vecs[9] = '{4'b0000, 32'h00EE_0000, 1'b0, 4'b0000, 5'd1, 1'b0, 8'hEE};

        do_reset();
        for (int v = 0; v < 10; v++) begin
            proc_onspawn = vecs[v].req;
            for (int p = 0; p < 4; p++) addr_a[p] = vecs[v].addrs[p*8 +: 8];
            deq = vecs[v].deq;
            cycle();
            chk($sformatf("vec%0d_ack", v),   32'(proc_spawn_ack), 32'(vecs[v].exp_ack));
            chk($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_cnt));
            chk($sformatf("vec%0d_empty", v), 32'(empty), 32'(vecs[v].exp_empty));
            chk($sformatf("vec%0d_head", v),  32'(deq_addr), 32'(vecs[v].exp_head));
        end

        // ---- proc 0 fills the FIFO; full blocks, push+pop while full is accepted
        do_reset();
        begin
            int n;
            n = 0;
            proc_onspawn = 4'b0001;
            addr_a[0]    = 8'h40;
            for (int c = 0; c < 40; c++) begin
                cycle();
                if (m_ack[0]) begin
                    n++;
                    addr_a[0] = 8'(8'h40 + n);
                end
            end
        end
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full",  32'(full), 32'd1);
        chk("fill_noack", 32'(proc_spawn_ack), 32'd0);
        deq = 1'b1;
        cycle();
        deq = 1'b0;
        chk("fullpp_ack",   32'(proc_spawn_ack), 32'd1);
        chk("fullpp_count", 32'(count), 32'd16);
        chk("fullpp_full",  32'(full), 32'd1);
        chk("fullpp_head",  32'(deq_addr), 32'h41);
        check_model("fullpp");
        proc_onspawn = '0;

        // ---- all four hold requests: strict rotation, never the same proc twice
        do_reset();
        for (int p = 0; p < 4; p++) addr_a[p] = 8'(8'hA0 + p);
        proc_onspawn = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk($sformatf("rr_order%0d", k), 32'(proc_spawn_ack), 32'(1 << (k % 4)));
        end
        proc_onspawn = '0;

        // ---- reset mid-cycle with count=5 and ack[2] pending
        do_reset();
        begin
            int seq [5] = '{0, 1, 0, 1, 2};
            for (int j = 0; j < 5; j++) begin
                proc_onspawn = 4'(1 << seq[j]);
                addr_a[seq[j]] = 8'(8'h50 + j);
                cycle();
            end
        end
        chk("pre_rst_count", 32'(count), 32'd5);
        chk("pre_rst_ack",   32'(proc_spawn_ack), 32'b0100);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_ack",   32'(proc_spawn_ack), 32'd0);
        #1;
        reset = 1'b0;
        model_reset();
        proc_onspawn = 4'b1111;
        cycle();
        chk("post_rst_grant", 32'(proc_spawn_ack), 32'b0001);
        chk("post_rst_count", 32'(count), 32'd1);
        proc_onspawn = '0;

        // ---- push 5, pop 3, push 2
        do_reset();
        for (int j = 0; j < 5; j++) begin
            proc_onspawn = 4'(1 << (j % 2));
            addr_a[j % 2] = 8'(8'h60 + j);
            cycle();
        end
        proc_onspawn = '0;
        deq = 1'b1;
        for (int j = 0; j < 3; j++) cycle();
        deq = 1'b0;
        for (int j = 0; j < 2; j++) begin
            proc_onspawn = 4'(1 << (j % 2));
            addr_a[j % 2] = 8'(8'h70 + j);
            cycle();
        end
        proc_onspawn = '0;
        chk("stats_count", 32'(count), 32'd4);
        chk("stats_head",  32'(deq_addr), 32'h63);
`ifdef SPAWN_QUEUE_STATS_EN
        chk("stats_peak",  32'(peak_count), 32'd5);
        chk("stats_total", 32'(spawn_total), 32'd7);
`endif

        // ---- randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (proc_onspawn[p] && m_ack[p]) begin
                    if ($urandom_range(0, 1) == 0) proc_onspawn[p] = 1'b0;
                    else addr_a[p] = 8'($urandom);
                end else if (!proc_onspawn[p] && $urandom_range(0, 2) != 0) begin
                    proc_onspawn[p] = 1'b1;
                    addr_a[p] = 8'($urandom);
                end
            end
            if (c < 400) deq = ($urandom_range(0, 4) == 0);
            else if (c < 800) deq = ($urandom_range(0, 1) == 0);
            else deq = ($urandom_range(0, 3) != 0);
            cycle();
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
